// File: rtl/uart_rx.sv
// Memory-mapped UART receive block: host bytes arrive over valid/ready, are
// buffered in a circular FIFO, and are read by the CPU through RXDATA/STATUS/CTRL.
module uart_rx #(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] BASE_TOP = 8'h81
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] addr,
    input  logic        w_en,
    input  logic [63:0] wdata,
    input  logic        r_en,
    output logic [63:0] rdata,
    output logic        rvalid,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    OFF_RXDATA = 8'h08;
    localparam logic [7:0]    OFF_STATUS = 8'h0C;
    localparam logic [7:0]    OFF_CTRL   = 8'h10;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rx_en_q, rx_en_d;
    logic          irq_en_q, irq_en_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          irq_q, irq_d;

    logic          sel, rd, wr, ctrl_wr;
    logic          empty, full, push, pop;
    logic [7:0]    off;
    logic [63:0]   rd_mux;
    logic          unused_bits;

    assign sel      = (addr[31:24] == BASE_TOP);
    assign off      = addr[7:0];
    assign rd       = r_en && sel;
    assign wr       = w_en && sel;
    assign ctrl_wr  = wr && (off == OFF_CTRL);
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign in_ready = rx_en_q && !full;
    assign push     = in_valid && in_ready;
    assign pop      = rd && (off == OFF_RXDATA) && !empty;

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign irq      = irq_q;

    assign unused_bits = ^{addr[63:32], addr[23:8], wdata[63:3]};

    // Read data reflects state before this cycle's push, pop or CTRL write.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_RXDATA: begin
                if (!empty) rd_mux[7:0] = mem_q[rptr_q];
            end
            OFF_STATUS: begin
                rd_mux[0]    = !empty;
                rd_mux[1]    = full;
                rd_mux[2]    = ovf_q;
                rd_mux[15:8] = 8'(count_q);
            end
            OFF_CTRL: begin
                rd_mux[1:0] = {irq_en_q, rx_en_q};
            end
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;
        wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        rx_en_d  = ctrl_wr ? wdata[0] : rx_en_q;
        irq_en_d = ctrl_wr ? wdata[1] : irq_en_q;
        ovf_d    = ovf_q;
        if (ctrl_wr && wdata[2]) ovf_d = 1'b0;
        // A fresh overflow in the same cycle as a clear is kept.
        if (in_valid && rx_en_q && full) ovf_d = 1'b1;
        rdata_d  = rd ? rd_mux : rdata_q;
        rvalid_d = rd;
        irq_d    = irq_en_q && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            rx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            rx_en_q  <= rx_en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx: host bytes are queued when accepted and
// compared when the CPU pops them through RXDATA.
module tb_uart_rx;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] addr;
    logic        w_en;
    logic [63:0] wdata;
    logic        r_en;
    logic [63:0] rdata;
    logic        rvalid;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb[$];
    bit          m_rx_en, m_irq_en, m_ovf, m_irq;
    logic [63:0] m_rdata;
    logic [63:0] obs_rdata;
    logic        obs_rvalid;

    uart_rx #(.DEPTH(DEPTH), .BASE_TOP(8'h81)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .w_en(w_en), .wdata(wdata),
        .r_en(r_en), .rdata(rdata), .rvalid(rvalid), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sb.delete();
        m_rx_en = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
        m_rdata = '0;
    endtask

    // One bus/host cycle, entered and left at a falling edge; updates the model.
    task automatic drive_cycle(input bit rd, input bit wr, input logic [7:0] top,
                               input logic [7:0] off, input logic [63:0] wd,
                               input bit v, input logic [7:0] b);
        int cnt;
        bit full_pre, hit, irq_next;
        r_en = rd; w_en = wr; addr = {32'h0, top, 16'h0, off}; wdata = wd;
        in_valid = v; in_data = b;
        cnt = sb.size();
        full_pre = (cnt == DEPTH);
        hit = (top == 8'h81);
        irq_next = m_irq_en && (cnt > 0);
        if (rd && hit) begin
            case (off)
                8'h08:   m_rdata = (cnt > 0) ? {56'b0, sb[0]} : 64'h0;
                8'h0C:   m_rdata = {48'b0, 8'(cnt), 5'b0, m_ovf, full_pre, cnt > 0};
                8'h10:   m_rdata = {62'b0, m_irq_en, m_rx_en};
                default: m_rdata = 64'h0;
            endcase
        end
        @(posedge clk);
        if (rd && hit && off == 8'h08 && cnt > 0) void'(sb.pop_front());
        if (v && m_rx_en && !full_pre) sb.push_back(b);
        if (wr && hit && off == 8'h10) begin
            m_rx_en = wd[0]; m_irq_en = wd[1];
            if (wd[2]) m_ovf = 0;
        end
        if (v && m_rx_en && full_pre) m_ovf = 1;
        m_irq = irq_next;
        @(negedge clk);
        r_en = 0; w_en = 0; in_valid = 0;
        obs_rdata = rdata; obs_rvalid = rvalid;
    endtask

    task automatic cpu_read(input logic [7:0] off);
        drive_cycle(1, 0, 8'h81, off, 64'h0, 0, 8'h0);
    endtask

    task automatic cpu_write(input logic [7:0] off, input logic [63:0] wd);
        drive_cycle(0, 1, 8'h81, off, wd, 0, 8'h0);
    endtask

    task automatic host_push(input logic [7:0] b);
        drive_cycle(0, 0, 8'h81, 8'h00, 64'h0, 1, b);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (rdata !== 64'h0 || rvalid !== 1'b0 || in_ready !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdata=%h rvalid=%b in_ready=%b irq=%b, need all 0",
                     rdata, rvalid, in_ready, irq);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cpu_read(8'h0C);
        checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_status: got rvalid=%b rdata=%h, need 1/0", obs_rvalid, obs_rdata);
        end
        cpu_read(8'h10);
        checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got rvalid=%b rdata=%h, need 1/0", obs_rvalid, obs_rdata);
        end
    endtask

    task automatic test_basic();
        cpu_write(8'h10, 64'h3);
        host_push(8'h41);
        host_push(8'h42);
        cpu_read(8'h0C);
        checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h0201 || obs_rdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL basic_status: got rvalid=%b rdata=%h, need 1/0201", obs_rvalid, obs_rdata);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_irq_high: got %b need 1", irq);
        end
        drive_cycle(0, 0, 8'h81, 8'h00, 64'h0, 0, 8'h0);
        checks++;
        if (obs_rvalid !== 1'b0 || obs_rdata !== 64'h0201) begin
            errors++;
            $display("[TB] FAIL basic_hold: got rvalid=%b rdata=%h, need 0/0201", obs_rvalid, obs_rdata);
        end
        for (int i = 0; i < 2; i++) begin
            cpu_read(8'h08);
            checks++;
            if (obs_rvalid !== 1'b1 || obs_rdata !== 64'(8'h41 + i) || obs_rdata !== m_rdata) begin
                errors++;
                $display("[TB] FAIL basic_pop%0d: got rvalid=%b rdata=%h, need 1/%h",
                         i, obs_rvalid, obs_rdata, 64'(8'h41 + i));
            end
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0 || irq !== 1'b0 || irq !== m_irq) begin
            errors++;
            $display("[TB] FAIL basic_final: got status=%h irq=%b, need 0/0", obs_rdata, irq);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH; i++) host_push(8'(i));
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_in_ready: got %b need 0", in_ready);
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0803) begin
            errors++;
            $display("[TB] FAIL full_status: got %h need 0803", obs_rdata);
        end
        repeat (3) host_push(8'h99);
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0807 || obs_rdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL overflow_status: got %h need 0807", obs_rdata);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read(8'h08);
            checks++;
            if (obs_rvalid !== 1'b1 || obs_rdata !== 64'(i)) begin
                errors++;
                $display("[TB] FAIL drain%0d: got rvalid=%b rdata=%h, need 1/%h", i, obs_rvalid, obs_rdata, 64'(i));
            end
        end
        cpu_read(8'h08);
        checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL empty_read: got rvalid=%b rdata=%h, need 1/0", obs_rvalid, obs_rdata);
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0004) begin
            errors++;
            $display("[TB] FAIL sticky_ovf: got %h need 0004", obs_rdata);
        end
        cpu_write(8'h10, 64'h7);
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %h need 0", obs_rdata);
        end
        cpu_read(8'h10);
        checks++;
        if (obs_rdata !== 64'h3) begin
            errors++;
            $display("[TB] FAIL ctrl_readback: got %h need 3", obs_rdata);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            host_push(8'(i + 16));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_ready%0d: got %b need 1", i, in_ready);
            end
            cpu_read(8'h08);
            checks++;
            if (obs_rvalid !== 1'b1 || obs_rdata !== 64'(i + 16) || obs_rdata !== m_rdata) begin
                errors++;
                $display("[TB] FAIL wrap_data%0d: got rvalid=%b rdata=%h, need 1/%h",
                         i, obs_rvalid, obs_rdata, 64'(i + 16));
            end
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL wrap_status: got %h need 0", obs_rdata);
        end
    endtask

    task automatic test_same_cycle();
        drive_cycle(1, 0, 8'h81, 8'h08, 64'h0, 1, 8'h55);
        checks++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL empty_pushpop: got rvalid=%b rdata=%h, need 1/0", obs_rvalid, obs_rdata);
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0101) begin
            errors++;
            $display("[TB] FAIL empty_pushpop_status: got %h need 0101", obs_rdata);
        end
        cpu_read(8'h08);
        checks++;
        if (obs_rdata !== 64'h55) begin
            errors++;
            $display("[TB] FAIL empty_pushpop_data: got %h need 55", obs_rdata);
        end
        for (int i = 0; i < DEPTH; i++) host_push(8'(8'hA0 + i));
        drive_cycle(1, 0, 8'h81, 8'h08, 64'h0, 1, 8'hEE);
        checks++;
        if (obs_rdata !== 64'hA0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_pushpop: got rdata=%h in_ready=%b, need a0/1", obs_rdata, in_ready);
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0705 || obs_rdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL full_pushpop_status: got %h need 0705", obs_rdata);
        end
        cpu_write(8'h10, 64'h7);
        while (sb.size() > 0) begin
            cpu_read(8'h08);
            checks++;
            if (obs_rdata !== m_rdata) begin
                errors++;
                $display("[TB] FAIL full_pushpop_drain: got %h need %h", obs_rdata, m_rdata);
            end
        end
    endtask

    task automatic test_rx_disable();
        host_push(8'h61);
        host_push(8'h62);
        drive_cycle(1, 1, 8'h81, 8'h10, 64'h2, 0, 8'h0);
        checks++;
        if (obs_rdata !== 64'h3) begin
            errors++;
            $display("[TB] FAIL rw_same_cycle: got %h need 3", obs_rdata);
        end
        repeat (3) host_push(8'h77);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_ready: got %b need 0", in_ready);
        end
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0201 || obs_rdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL disabled_status: got %h need 0201", obs_rdata);
        end
        cpu_read(8'h08);
        checks++;
        if (obs_rdata !== 64'h61) begin
            errors++;
            $display("[TB] FAIL disabled_drain: got %h need 61", obs_rdata);
        end
        drive_cycle(1, 0, 8'h80, 8'h08, 64'h0, 0, 8'h0);
        checks++;
        if (obs_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unselected_read: got rvalid=%b need 0", obs_rvalid);
        end
        drive_cycle(0, 1, 8'h80, 8'h10, 64'h1, 0, 8'h0);
        cpu_read(8'h10);
        checks++;
        if (obs_rdata !== 64'h2) begin
            errors++;
            $display("[TB] FAIL unselected_write: got ctrl=%h need 2", obs_rdata);
        end
        cpu_read(8'h08);
        checks++;
        if (obs_rdata !== 64'h62) begin
            errors++;
            $display("[TB] FAIL unselected_nopop: got %h need 62", obs_rdata);
        end
    endtask

    task automatic test_reset_midstream();
        cpu_write(8'h10, 64'h3);
        for (int i = 0; i < 3; i++) host_push(8'(8'hC0 + i));
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0301 || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midstream_pre: got status=%h irq=%b, need 0301/1", obs_rdata, irq);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (rdata !== 64'h0 || rvalid !== 1'b0 || in_ready !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midstream_reset: got rdata=%h rvalid=%b in_ready=%b irq=%b, need all 0",
                     rdata, rvalid, in_ready, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_read(8'h0C);
        checks++;
        if (obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_status: got %h need 0", obs_rdata);
        end
        cpu_read(8'h10);
        checks++;
        if (obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_ctrl: got %h need 0", obs_rdata);
        end
        cpu_read(8'h08);
        checks++;
        if (obs_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_data: got %h need 0", obs_rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0; r_en = 0; w_en = 0; addr = '0; wdata = '0;
        in_valid = 0; in_data = '0;
        obs_rdata = '0; obs_rvalid = 0;
        model_reset();
        test_reset();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_same_cycle();
        test_rx_disable();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
